// File: rtl/id_ex_stage.sv
// id_ex_stage: ID/EX pipeline register of the 5-stage MIPS pipeline.
//
// Captures the EX/MEM/WB control bundles and the ID operands on every rising
// edge. It also contains the load-use hazard detector, which stalls PC/IF-ID
// and injects a bubble into EX. Branch/jump flush and downstream hold are
// also handled here.
//
// Ports:
//   clk, rst            rising-edge clock, synchronous active-high reset
//   id_ex/id_mem/id_wb  control bundles from the ID control unit
//   id_opcode           opcode, decoded here to find which sources are read
//   id_rs/rt/rd         register indices
//   id_rs_data/rt_data  register-file read data
//   id_imm, id_pc4      extended immediate, PC+4
//   id_funct            funct field
//   flush_i             kill the instruction entering EX
//   hold_i              freeze the register (downstream multicycle stall)
//   ex_*                registered copies of the above
//   ex_valid            EX slot holds a real instruction
//   stall_o             freeze PC and IF/ID this cycle
//   stall_cnt           (only with ID_EX_STALL_CNT_EN) saturating count of
//                       inserted hazard bubbles
//
// Optional feature macro: ID_EX_STALL_CNT_EN
module id_ex_stage #(
  parameter int unsigned DW = 32,
  parameter int unsigned RW = 5
) (
  input  logic          clk,
  input  logic          rst,
  input  logic [3:0]    id_ex,
  input  logic [2:0]    id_mem,
  input  logic [1:0]    id_wb,
  input  logic [5:0]    id_opcode,
  input  logic [RW-1:0] id_rs,
  input  logic [RW-1:0] id_rt,
  input  logic [RW-1:0] id_rd,
  input  logic [DW-1:0] id_rs_data,
  input  logic [DW-1:0] id_rt_data,
  input  logic [DW-1:0] id_imm,
  input  logic [DW-1:0] id_pc4,
  input  logic [5:0]    id_funct,
  input  logic          flush_i,
  input  logic          hold_i,
  output logic [3:0]    ex_ex,
  output logic [2:0]    ex_mem,
  output logic [1:0]    ex_wb,
  output logic [RW-1:0] ex_rs,
  output logic [RW-1:0] ex_rt,
  output logic [RW-1:0] ex_rd,
  output logic [DW-1:0] ex_rs_data,
  output logic [DW-1:0] ex_rt_data,
  output logic [DW-1:0] ex_imm,
  output logic [DW-1:0] ex_pc4,
  output logic [5:0]    ex_funct,
  output logic          ex_valid,
  output logic          stall_o
`ifdef ID_EX_STALL_CNT_EN
  ,
  output logic [15:0]   stall_cnt
`endif
);

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] OP_J     = 6'b000010;

  logic rs_used;
  logic rt_used;
  logic hazard;

  // Only a valid load (MemRead) in EX writing a non-zero register can
  // produce a load-use hazard against the ID instruction's sources.
  always_comb begin
    rs_used = (id_opcode != OP_J);
    rt_used = (id_opcode == OP_RTYPE) || (id_opcode == OP_BEQ) ||
              (id_opcode == OP_SW);
    hazard  = ex_mem[2] && ex_valid && (ex_rt != '0) &&
              ((rs_used && (ex_rt == id_rs)) || (rt_used && (ex_rt == id_rt)));
    stall_o = (hazard || hold_i) && !flush_i && !rst;
  end

  // Data fields are captured on flush, bubble and normal cycles alike; only
  // the control bundles and ex_valid differ between those cases.
  always_ff @(posedge clk) begin
    if (rst) begin
      ex_ex      <= '0;
      ex_mem     <= '0;
      ex_wb      <= '0;
      ex_rs      <= '0;
      ex_rt      <= '0;
      ex_rd      <= '0;
      ex_rs_data <= '0;
      ex_rt_data <= '0;
      ex_imm     <= '0;
      ex_pc4     <= '0;
      ex_funct   <= '0;
      ex_valid   <= 1'b0;
    end else if (flush_i || !hold_i) begin
      if (flush_i || hazard) begin
        ex_ex    <= '0;
        ex_mem   <= '0;
        ex_wb    <= '0;
        ex_valid <= 1'b0;
      end else begin
        ex_ex    <= id_ex;
        ex_mem   <= id_mem;
        ex_wb    <= id_wb;
        ex_valid <= 1'b1;
      end
      ex_rs      <= id_rs;
      ex_rt      <= id_rt;
      ex_rd      <= id_rd;
      ex_rs_data <= id_rs_data;
      ex_rt_data <= id_rt_data;
      ex_imm     <= id_imm;
      ex_pc4     <= id_pc4;
      ex_funct   <= id_funct;
    end
  end

`ifdef ID_EX_STALL_CNT_EN
  always_ff @(posedge clk) begin
    if (rst) begin
      stall_cnt <= '0;
    end else if (!flush_i && !hold_i && hazard && (stall_cnt != '1)) begin
      stall_cnt <= stall_cnt + 16'd1;
    end
  end
`endif

endmodule

// File: tb/tb_id_ex_stage.sv
module tb_id_ex_stage;
  localparam int DW = 32;
  localparam int RW = 5;
  localparam int VW = 4 + 3 + 2 + 3 * RW + 4 * DW + 6 + 1;

  logic clk = 1'b0;
  logic rst = 1'b0;
  logic [3:0] id_ex = '0;
  logic [2:0] id_mem = '0;
  logic [1:0] id_wb = '0;
  logic [5:0] id_opcode = '0;
  logic [RW-1:0] id_rs = '0, id_rt = '0, id_rd = '0;
  logic [DW-1:0] id_rs_data = '0, id_rt_data = '0, id_imm = '0, id_pc4 = '0;
  logic [5:0] id_funct = '0;
  logic flush_i = 1'b0, hold_i = 1'b0;
  logic [3:0] ex_ex;
  logic [2:0] ex_mem;
  logic [1:0] ex_wb;
  logic [RW-1:0] ex_rs, ex_rt, ex_rd;
  logic [DW-1:0] ex_rs_data, ex_rt_data, ex_imm, ex_pc4;
  logic [5:0] ex_funct;
  logic ex_valid, stall_o;
`ifdef ID_EX_STALL_CNT_EN
  logic [15:0] stall_cnt;
`endif

  int total = 0;
  int bad = 0;

  // Reference model: what the EX slot should hold.
  logic [3:0] m_ex;
  logic [2:0] m_mem;
  logic [1:0] m_wb;
  logic [RW-1:0] m_rs, m_rt, m_rd;
  logic [DW-1:0] m_rs_data, m_rt_data, m_imm, m_pc4;
  logic [5:0] m_funct;
  logic m_valid;
  int m_cnt;

  id_ex_stage #(.DW(DW), .RW(RW)) dut (
    .clk(clk), .rst(rst), .id_ex(id_ex), .id_mem(id_mem), .id_wb(id_wb),
    .id_opcode(id_opcode), .id_rs(id_rs), .id_rt(id_rt), .id_rd(id_rd),
    .id_rs_data(id_rs_data), .id_rt_data(id_rt_data), .id_imm(id_imm),
    .id_pc4(id_pc4), .id_funct(id_funct), .flush_i(flush_i), .hold_i(hold_i),
    .ex_ex(ex_ex), .ex_mem(ex_mem), .ex_wb(ex_wb), .ex_rs(ex_rs), .ex_rt(ex_rt),
    .ex_rd(ex_rd), .ex_rs_data(ex_rs_data), .ex_rt_data(ex_rt_data),
    .ex_imm(ex_imm), .ex_pc4(ex_pc4), .ex_funct(ex_funct), .ex_valid(ex_valid),
    .stall_o(stall_o)
`ifdef ID_EX_STALL_CNT_EN
    , .stall_cnt(stall_cnt)
`endif
  );

  always #5 clk = ~clk;

  function automatic logic [VW-1:0] obs_vec();
    return {ex_ex, ex_mem, ex_wb, ex_rs, ex_rt, ex_rd, ex_rs_data, ex_rt_data,
            ex_imm, ex_pc4, ex_funct, ex_valid};
  endfunction

  function automatic logic [VW-1:0] exp_vec();
    return {m_ex, m_mem, m_wb, m_rs, m_rt, m_rd, m_rs_data, m_rt_data,
            m_imm, m_pc4, m_funct, m_valid};
  endfunction

  // Does the ID instruction read the register the EX-stage load writes?
  function automatic bit model_hazard();
    bit reads_rs, reads_rt, load_in_ex;
    reads_rs   = !(id_opcode == 6'd2);
    reads_rt   = (id_opcode == 6'd0) || (id_opcode == 6'd4) || (id_opcode == 6'd43);
    load_in_ex = m_valid && m_mem[2] && (m_rt != 0);
    return load_in_ex && ((reads_rs && m_rt == id_rs) || (reads_rt && m_rt == id_rt));
  endfunction

  function automatic bit model_stall();
    return !rst && !flush_i && (hold_i || model_hazard());
  endfunction

  task automatic take_inputs(input bit real_instr);
    m_ex    = real_instr ? id_ex  : 4'd0;
    m_mem   = real_instr ? id_mem : 3'd0;
    m_wb    = real_instr ? id_wb  : 2'd0;
    m_valid = real_instr;
    m_rs = id_rs; m_rt = id_rt; m_rd = id_rd;
    m_rs_data = id_rs_data; m_rt_data = id_rt_data;
    m_imm = id_imm; m_pc4 = id_pc4; m_funct = id_funct;
  endtask

  // Advance model with the inputs present before the edge, then wait past it.
  task automatic tick();
    if (rst) begin
      {m_ex, m_mem, m_wb, m_rs, m_rt, m_rd, m_rs_data, m_rt_data, m_imm, m_pc4,
       m_funct, m_valid} = '0;
      m_cnt = 0;
    end else if (flush_i) begin
      take_inputs(1'b0);
    end else if (hold_i) begin
      // slot frozen
    end else if (model_hazard()) begin
      take_inputs(1'b0);
      if (m_cnt < 65535) m_cnt++;
    end else begin
      take_inputs(1'b1);
    end
    @(posedge clk);
    #1;
  endtask

  task automatic rand_inputs();
    logic [5:0] ops [7];
    ops = '{6'd0, 6'd35, 6'd43, 6'd4, 6'd12, 6'd2, 6'd8};
    id_ex = 4'($urandom); id_mem = 3'($urandom); id_wb = 2'($urandom);
    id_opcode = ops[$urandom_range(0, 6)];
    id_rs = RW'($urandom_range(0, 3)); id_rt = RW'($urandom_range(0, 3));
    id_rd = RW'($urandom);
    id_rs_data = $urandom; id_rt_data = $urandom; id_imm = $urandom;
    id_pc4 = $urandom; id_funct = 6'($urandom);
  endtask

  task automatic set_instr(input logic [5:0] op, input logic [3:0] e, input logic [2:0] m,
                           input logic [1:0] w, input int rs, input int rt, input int rd);
    id_opcode = op; id_ex = e; id_mem = m; id_wb = w;
    id_rs = RW'(rs); id_rt = RW'(rt); id_rd = RW'(rd);
    id_rs_data = 32'h11111111; id_rt_data = 32'h22222222;
    id_imm = 32'h33; id_pc4 = 32'h400; id_funct = 6'h20;
  endtask

  task automatic test_reset();
    for (int i = 0; i < 2; i++) begin
      rand_inputs(); flush_i = 1'($urandom); hold_i = 1'($urandom); rst = 1'b1;
      tick();
      rand_inputs();
      #1;
      total++;
      if (obs_vec() !== '0) begin
        bad++; $display("FAIL reset_outputs got=%h want=0", obs_vec());
      end
      total++;
      if (stall_o !== 1'b0) begin
        bad++; $display("FAIL reset_stall got=%b want=0", stall_o);
      end
    end
    rst = 1'b0; flush_i = 1'b0; hold_i = 1'b0;
    set_instr(6'd0, 4'b1100, 3'b000, 2'b10, 1, 2, 3);
    tick();
    total++;
    if (obs_vec() !== {4'b1100, 3'b000, 2'b10, 5'd1, 5'd2, 5'd3, 32'h11111111,
                       32'h22222222, 32'h33, 32'h400, 6'h20, 1'b1}) begin
      bad++; $display("FAIL first_capture got=%h want=%h", obs_vec(), exp_vec());
    end
  endtask

  task automatic test_load_use();
    set_instr(6'd35, 4'b0001, 3'b100, 2'b11, 1, 8, 0);
    tick();
    set_instr(6'd0, 4'b1100, 3'b000, 2'b10, 8, 9, 10);
    #1;
    total++;
    if (stall_o !== 1'b1) begin bad++; $display("FAIL loaduse_stall got=%b want=1", stall_o); end
    tick();
    total++;
    if ({ex_ex, ex_mem, ex_wb, ex_valid} !== '0) begin
      bad++; $display("FAIL loaduse_bubble got=%h want=0", {ex_ex, ex_mem, ex_wb, ex_valid});
    end
    total++;
    if (stall_o !== 1'b0) begin bad++; $display("FAIL loaduse_single got=%b want=0", stall_o); end
    tick();
    total++;
    if ({ex_ex, ex_wb, ex_rs, ex_valid} !== {4'b1100, 2'b10, 5'd8, 1'b1}) begin
      bad++; $display("FAIL loaduse_capture got=%h want=%h", {ex_ex, ex_wb, ex_rs, ex_valid},
                      {4'b1100, 2'b10, 5'd8, 1'b1});
    end
`ifdef ID_EX_STALL_CNT_EN
    total++;
    if (stall_cnt !== 16'd1) begin bad++; $display("FAIL loaduse_cnt got=%0d want=1", stall_cnt); end
`endif
  endtask

  task automatic test_no_false_stall();
    set_instr(6'd35, 4'b0001, 3'b100, 2'b11, 1, 8, 0);
    tick();
    set_instr(6'd12, 4'b0001, 3'b000, 2'b10, 9, 8, 0);
    #1;
    total++;
    if (stall_o !== 1'b0) begin bad++; $display("FAIL andi_rt got=%b want=0", stall_o); end
    tick();
    set_instr(6'd35, 4'b0001, 3'b100, 2'b11, 1, 0, 0);
    tick();
    set_instr(6'd0, 4'b1100, 3'b000, 2'b10, 0, 0, 4);
    #1;
    total++;
    if (stall_o !== 1'b0) begin bad++; $display("FAIL reg_zero got=%b want=0", stall_o); end
    tick();
  endtask

  task automatic test_flush_vs_hazard();
    set_instr(6'd35, 4'b0001, 3'b100, 2'b11, 1, 8, 0);
    tick();
    set_instr(6'd0, 4'b1100, 3'b000, 2'b10, 8, 8, 5);
    flush_i = 1'b1;
    #1;
    total++;
    if (stall_o !== 1'b0) begin bad++; $display("FAIL flush_stall got=%b want=0", stall_o); end
    tick();
    flush_i = 1'b0;
    total++;
    if ({ex_ex, ex_mem, ex_wb, ex_valid} !== '0) begin
      bad++; $display("FAIL flush_slot got=%h want=0", {ex_ex, ex_mem, ex_wb, ex_valid});
    end
  endtask

  task automatic test_hold();
    logic [VW-1:0] snap;
    set_instr(6'd0, 4'b1100, 3'b000, 2'b10, 3, 4, 5);
    tick();
    snap = exp_vec();
    hold_i = 1'b1;
    for (int i = 0; i < 3; i++) begin
      rand_inputs();
      #1;
      total++;
      if (stall_o !== 1'b1) begin bad++; $display("FAIL hold_stall[%0d] got=%b want=1", i, stall_o); end
      tick();
      total++;
      if (obs_vec() !== snap) begin
        bad++; $display("FAIL hold_frozen[%0d] got=%h want=%h", i, obs_vec(), snap);
      end
    end
    hold_i = 1'b0;
    rand_inputs();
    tick();
    total++;
    if (obs_vec() !== exp_vec()) begin
      bad++; $display("FAIL hold_release got=%h want=%h", obs_vec(), exp_vec());
    end
  endtask

  task automatic test_back_to_back();
    for (int i = 0; i < 400; i++) begin
      rand_inputs();
      rst = ($urandom_range(0, 49) == 0);
      flush_i = ($urandom_range(0, 9) == 0);
      hold_i = ($urandom_range(0, 9) == 0);
      #1;
      total++;
      if (stall_o !== model_stall()) begin
        bad++; $display("FAIL rand_stall[%0d] got=%b want=%b", i, stall_o, model_stall());
      end
      tick();
      total++;
      if (obs_vec() !== exp_vec()) begin
        bad++; $display("FAIL rand_slot[%0d] got=%h want=%h", i, obs_vec(), exp_vec());
      end
`ifdef ID_EX_STALL_CNT_EN
      total++;
      if (stall_cnt !== 16'(m_cnt)) begin
        bad++; $display("FAIL rand_cnt[%0d] got=%0d want=%0d", i, stall_cnt, m_cnt);
      end
`endif
    end
    rst = 1'b0; flush_i = 1'b0; hold_i = 1'b0;
  endtask

`ifdef ID_EX_STALL_CNT_EN
  task automatic test_saturation();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    for (int i = 0; i < 65537; i++) begin
      set_instr(6'd35, 4'b0001, 3'b100, 2'b11, 1, 5, 0);
      tick();
      set_instr(6'd0, 4'b1100, 3'b000, 2'b10, 5, 6, 7);
      tick();
    end
    total++;
    if (stall_cnt !== 16'hFFFF) begin bad++; $display("FAIL cnt_saturate got=%h want=ffff", stall_cnt); end
    total++;
    if (stall_cnt !== 16'(m_cnt)) begin bad++; $display("FAIL cnt_model got=%h want=%h", stall_cnt, m_cnt); end
  endtask
`endif

  initial begin
    test_reset();
    test_load_use();
    test_no_false_stall();
    test_flush_vs_hazard();
    test_hold();
    test_back_to_back();
`ifdef ID_EX_STALL_CNT_EN
    test_saturation();
`endif
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
